// File: rtl/mm_stream_sequencer.sv
// Purpose: streams 18 operand nibbles into the 3x3 multiplier, pulses compute, reads back 9 products.
// Latency: 101 cycles from start to done with no stalls (OS_SETTLE=2); every output is a register.
// Backpressure: in_valid low stalls in LD_ACC, res_ready low holds res_data/res_idx in RD_OUT.
module mm_stream_sequencer #(
    parameter int OS_SETTLE = 2
) (
    input  logic       clk,
    input  logic       mr,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       res_valid,
    output logic [9:0] res_data,
    output logic [3:0] res_idx,
    input  logic       res_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] mm_i,
    output logic       mm_ic,
    output logic [3:0] mm_os,
    output logic       mm_en,
    output logic       mm_mr,
    input  logic [9:0] mm_matrix
);

    localparam int SW = (OS_SETTLE > 1) ? $clog2(OS_SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(OS_SETTLE - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_LD_ACC,
        S_LD_PULSE,
        S_LD_GAP,
        S_CP_PULSE,
        S_CP_GAP,
        S_RD_SET,
        S_RD_OUT,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [4:0]    k, k_d, k_inc;
    logic [SW-1:0] settle, settle_d;
    logic [3:0]    mm_i_d, mm_os_d, res_idx_d;
    logic [9:0]    res_data_d;

    assign k_inc = k + 5'd1;

    // Next-state and next values of the datapath registers (element counter, settle timer, mm_i, mm_os, result).
    always_comb begin
        state_d    = state;
        k_d        = k;
        settle_d   = settle;
        mm_i_d     = mm_i;
        mm_os_d    = mm_os;
        res_data_d = res_data;
        res_idx_d  = res_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                k_d     = 5'd0;
                state_d = S_LD_ACC;
            end
            S_LD_ACC: begin
                if (in_valid && in_ready) begin
                    mm_i_d  = in_data;
                    state_d = S_LD_PULSE;
                end
            end
            S_LD_PULSE: begin
                state_d = S_LD_GAP;
            end
            S_LD_GAP: begin
                if (k == 5'd17) begin
                    k_d     = 5'd0;
                    state_d = S_CP_PULSE;
                end else begin
                    k_d     = k_inc;
                    state_d = S_LD_ACC;
                end
            end
            S_CP_PULSE: begin
                state_d = S_CP_GAP;
            end
            S_CP_GAP: begin
                if (k == 5'd8) begin
                    k_d      = 5'd0;
                    settle_d = '0;
                    mm_os_d  = 4'd0;
                    state_d  = S_RD_SET;
                end else begin
                    k_d     = k_inc;
                    state_d = S_CP_PULSE;
                end
            end
            S_RD_SET: begin
                if (settle == SETTLE_LAST) begin
                    res_data_d = mm_matrix;
                    res_idx_d  = k[3:0];
                    state_d    = S_RD_OUT;
                end else begin
                    settle_d = settle + SW'(1);
                end
            end
            S_RD_OUT: begin
                if (res_ready) begin
                    if (k == 5'd8) begin
                        mm_os_d = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        k_d      = k_inc;
                        settle_d = '0;
                        mm_os_d  = k_inc[3:0];
                        state_d  = S_RD_SET;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; state-decoded outputs are registered from the next state so they
    // line up with it. mm_ic is registered from the current state instead: the strobe then rises one
    // cycle after mm_i is loaded and falls a cycle before mm_i may change again.
    always_ff @(posedge clk) begin
        if (!mr) begin
            state     <= S_IDLE;
            k         <= 5'd0;
            settle    <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 10'd0;
            res_idx   <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mm_i      <= 4'd0;
            mm_ic     <= 1'b0;
            mm_os     <= 4'd0;
            mm_en     <= 1'b0;
            mm_mr     <= 1'b1;
        end else begin
            state     <= state_d;
            k         <= k_d;
            settle    <= settle_d;
            in_ready  <= (state_d == S_LD_ACC);
            res_valid <= (state_d == S_RD_OUT);
            res_data  <= res_data_d;
            res_idx   <= res_idx_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            mm_i      <= mm_i_d;
            mm_ic     <= (state == S_LD_PULSE) || (state == S_CP_PULSE);
            mm_os     <= mm_os_d;
            mm_en     <= (state_d != S_IDLE);
            mm_mr     <= (state_d == S_CLEAR);
        end
    end

endmodule

// File: doc/mm_stream_sequencer.md
# mm_stream_sequencer

Front-end controller for the 3x3 matrix multiplier. It accepts the 18 four-bit operand elements (matrix A then matrix B, row-major) over a valid/ready stream and replays them into the multiplier as the `i`/`ic` load sequence. It then issues the 9 compute `ic` pulses and walks `os` 0..8, returning the nine 10-bit products as a valid/ready result stream. It sits between the system bus/testbench and the multiplier, replacing hand-timed `ic`/`os` driving.

## Interface
- `OS_SETTLE`, 2: clk cycles `mm_os` is held before `mm_matrix` is captured (≥1).
- `clk` in 1: single clock; all state changes on rising edge.
- `mr` in 1: synchronous, active-low reset.
- `start` in 1: begin one multiply job; sampled in IDLE only.
- `in_valid` in 1: operand element valid.
- `in_data` in 4: operand element, unsigned.
- `in_ready` out 1: sequencer accepts `in_data` this cycle.
- `res_valid` out 1: result element valid.
- `res_data` out 10: product element, unsigned.
- `res_idx` out 4: result index 0..8 (row-major C[r][c] = 3r+c).
- `res_ready` in 1: result consumer accepts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after result 8 is accepted.
- `mm_i` out 4: to multiplier `i`.
- `mm_ic` out 1: to multiplier `ic` (load/compute strobe).
- `mm_os` out 4: to multiplier `os`.
- `mm_en` out 1: to multiplier `en`.
- `mm_mr` out 1: to multiplier `mr` (active-high clear).
- `mm_matrix` in 10: from multiplier output.

## Operation
- All outputs are registered. Reset values: `in_ready`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0, `mm_i`=0, `mm_ic`=0, `mm_os`=0, `mm_en`=0, `mm_mr`=1 (multiplier held clear while the sequencer is in reset).
- FSM: IDLE → CLEAR → LD_ACC → LD_PULSE → LD_GAP → (LD_ACC ×18) → CP_PULSE → CP_GAP → (×9) → RD_SET → RD_OUT → (×9) → DONE → IDLE.
- IDLE: `mm_mr`=0, `mm_en`=0. `start`=1 → CLEAR.
- CLEAR: `mm_mr`=1 for exactly one cycle; `mm_en`=1 from here until IDLE; element counter `k`=0.
- LD_ACC: `in_ready`=1. On `in_valid && in_ready`, `mm_i`←`in_data` → LD_PULSE. Without `in_valid`, stall indefinitely with `mm_ic`=0.
- LD_PULSE: `mm_ic`=1 for one cycle, `mm_i` unchanged.
- LD_GAP: `mm_ic`=0 for one cycle. `k`++. `k`=18 → CP_PULSE with `k`=0, otherwise → LD_ACC.
- CP_PULSE/CP_GAP: same 1-high/1-low `mm_ic` pattern, 9 times. `mm_i` holds its last loaded value. `in_ready`=0.
- RD_SET: `mm_os`←`k` on entry, then wait `OS_SETTLE` cycles. On the last settle cycle, `res_data`←`mm_matrix` and `res_idx`←`k`.
- RD_OUT: `res_valid`=1. `res_data`/`res_idx` are held stable until `res_ready`. On handshake, `k`++ → RD_SET, or → DONE if `k` was 8.
- DONE: `done`=1 for one cycle, `mm_os`←0 → IDLE.
- `start` while `busy` is ignored. `in_valid` outside LD_ACC is ignored; no element is consumed.
- Width: products are ≤ 3·15·15 = 675; 10 bits with no saturation logic.

## Timing
- `mm_i` is stable ≥1 clk before the `mm_ic` rise and ≥1 clk after its fall.
- `mm_ic` is never high two consecutive cycles, and there are exactly 27 high pulses per job.
- Minimum job latency, with `in_valid`=`res_ready`=1 throughout and `start` sampled at edge 0:
  - CLEAR: cycle 1.
  - Loads: cycles 2–55.
  - Compute: cycles 56–73.
  - Reads: 9·(`OS_SETTLE`+1) = 27 cycles (cycles 74–100).
  - `done`: cycle 101.
- Reset mid-job: at the first edge with `mr`=0, the FSM returns to IDLE and all outputs take their reset values, including `mm_mr`=1 (multiplier cleared). Partial operands are discarded.

## Test plan
- Reset check: hold `mr`=0 for 3 cycles → all outputs at reset values; `mm_mr`=1. Release → `mm_mr`=0, `busy`=0.
- Basic job: stream 1,4,5,4,5,6,0,0,0,10,11,7,13,14,9,2,3,4 → results idx0..8 = 72,82,63,117,132,97,0,0,0; `done` at cycle 101; exactly 27 `mm_ic` pulses.
- Backpressure: random `in_valid` gaps and `res_ready` low for 5 cycles at idx 3 → same results; `res_data`=117 held stable while stalled; no extra `mm_ic` pulses.
- Max values: all 18 elements = 15 → all nine results = 675.
- Reset mid-load: assert `mr`=0 after element 7 → IDLE, `mm_mr`=1. A fresh job then gives the correct results.
- `start` while busy: pulse `start` during compute → no restart; `done` appears once.
